milley_sequence_transmitter: RTL and testbench
==============================================

MILLEY_SEQUENCE_TRANSMITTER -- requirements
Module: milley_sequence_transmitter

Interface
REQ-001 Parameter: SYMBOLS, default 4, meaning number of 2-bit data symbols per frame (range 2..16).
REQ-002 Parameter: GAP_CYCLES, default 2, meaning idle cycles inserted between repeated frames (range 0..15).
REQ-003 Parameter: PREAMBLE_SYM, default 2'b11, meaning the start-of-frame symbol sent before each frame.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to begin a transmission; sampled in IDLE only.
REQ-007 data_in  input  2*SYMBOLS  frame payload; symbol 0 = bits [2*SYMBOLS-1:2*SYMBOLS-2].
REQ-008 repeat_count  input  4  extra frame repetitions; total frames = repeat_count+1.
REQ-009 ready  input  1  downstream (Mealy receiver side) accepts current symbol this cycle.
REQ-010 a  output  2  transmitted symbol, registered.
REQ-011 a_valid  output  1  a carries a symbol, registered.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the last symbol of the last frame is accepted.

Function
REQ-014 The block SHALL implement states IDLE, PREAMBLE, DATA, GAP; all outputs registered.
REQ-015 IDLE: a=2'b00, a_valid=0, busy=0; on start=1 it SHALL latch data_in into a payload copy and shift register, latch repeat_count into a frame counter, and enter PREAMBLE next cycle.
REQ-016 Transfer rule: a symbol is accepted only in a cycle with a_valid=1 and ready=1.
REQ-017 While a_valid=1 and ready=0, a and a_valid SHALL hold stable.
REQ-018 PREAMBLE: a=PREAMBLE_SYM, a_valid=1; on acceptance it SHALL enter DATA with symbol index 0.
REQ-019 DATA: a = top 2 bits of shift register; on acceptance shift left by 2 and increment index.
REQ-020 On acceptance of symbol SYMBOLS-1: if frame counter = 0, go to IDLE and pulse done for exactly one cycle (coincident with IDLE's first cycle); else decrement frame counter and go to GAP.
REQ-021 GAP: a=2'b00, a_valid=0, busy=1 for exactly GAP_CYCLES cycles, then PREAMBLE with shift register reloaded from payload copy.
REQ-022 GAP_CYCLES=0: DATA SHALL go directly to PREAMBLE (reload included), no idle cycle between frames.
REQ-023 With ready held high, a frame SHALL occupy exactly SYMBOLS+1 consecutive valid cycles; first symbol appears the cycle after start is sampled.
REQ-024 start while busy=1 SHALL be ignored; data_in and repeat_count changes after latching SHALL not affect the transmission.
REQ-025 ready asserted while a_valid=0 SHALL have no effect.
REQ-026 Symbol index and frame counter SHALL not wrap; repeat_count=15 gives exactly 16 frames.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, a=2'b00, a_valid=0, busy=0, done=0, counters and shift register to 0.
REQ-028 Reset asserted mid-frame SHALL abort with no done pulse; after release the block SHALL wait in IDLE for a new start.
REQ-029 First start SHALL be honoured on the first rising edge with reset=1.

Verification
REQ-030 SYMBOLS=4, data_in=8'b10_01_11_00, repeat_count=0, ready=1 -> a = 11,10,01,11,00 on 5 consecutive cycles, a_valid high for those 5 only, done pulse next cycle, busy low with it.
REQ-031 Same payload, repeat_count=1, GAP_CYCLES=2 -> two identical 5-symbol frames separated by exactly 2 cycles of a_valid=0, a=00; single done after second frame.
REQ-032 ready low for 3 cycles while a=10 -> a stays 10, a_valid stays 1; sequence resumes with 01 after ready returns high; total output sequence unchanged.
REQ-033 start pulsed and data_in changed to 8'hFF during transmission -> output remains original 11,10,01,11,00; no second frame.
REQ-034 reset driven low while a=01 (mid-DATA), asynchronously between edges -> a=00, a_valid=0, busy=0 immediately, no done; new start after release yields full frame from preamble.
REQ-035 GAP_CYCLES=0, repeat_count=2, ready=1 -> 15 consecutive valid cycles (three back-to-back frames), one done pulse.

Source files
------------

// File: rtl/milley_sequence_transmitter.sv
// Framed 2-bit symbol transmitter: preamble + SYMBOLS data symbols per frame,
// repeated repeat_count+1 times with GAP_CYCLES idle cycles between frames.
module milley_sequence_transmitter #(
  parameter int          SYMBOLS      = 4,
  parameter int          GAP_CYCLES   = 2,
  parameter logic [1:0]  PREAMBLE_SYM = 2'b11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2*SYMBOLS-1:0]   data_in,
  input  logic [3:0]             repeat_count,
  input  logic                   ready,
  output logic [1:0]             a,
  output logic                   a_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int W     = 2 * SYMBOLS;
  localparam int IDX_W = (SYMBOLS > 2) ? $clog2(SYMBOLS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SYMBOLS - 1);
  localparam logic [3:0]       GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    GAP      = 2'd3
  } state_t;

  state_t           state_q;
  logic [W-1:0]     payload_q;
  logic [W-1:0]     shreg_q;
  logic [W-1:0]     shreg_d;
  logic [3:0]       frame_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       gap_q;
  logic [1:0]       a_q;
  logic             a_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;

  assign accept  = a_valid_q & ready;
  assign shreg_d = shreg_q << 2;

  assign a       = a_q;
  assign a_valid = a_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      payload_q <= '0;
      shreg_q   <= '0;
      frame_q   <= 4'd0;
      idx_q     <= '0;
      gap_q     <= 4'd0;
      a_q       <= 2'b00;
      a_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            payload_q <= data_in;
            shreg_q   <= data_in;
            frame_q   <= repeat_count;
            idx_q     <= '0;
            state_q   <= PREAMBLE;
            a_q       <= PREAMBLE_SYM;
            a_valid_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        PREAMBLE: begin
          if (accept) begin
            state_q <= DATA;
            idx_q   <= '0;
            a_q     <= shreg_q[W-1 -: 2];
          end
        end
        DATA: begin
          if (accept) begin
            if (idx_q == IDX_LAST) begin
              if (frame_q == 4'd0) begin
                state_q   <= IDLE;
                a_q       <= 2'b00;
                a_valid_q <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
              end else begin
                frame_q <= frame_q - 4'd1;
                // With no gap the next preamble follows the last symbol directly.
                if (GAP_CYCLES == 0) begin
                  state_q <= PREAMBLE;
                  shreg_q <= payload_q;
                  a_q     <= PREAMBLE_SYM;
                end else begin
                  state_q   <= GAP;
                  gap_q     <= 4'd0;
                  a_q       <= 2'b00;
                  a_valid_q <= 1'b0;
                end
              end
            end else begin
              shreg_q <= shreg_d;
              a_q     <= shreg_d[W-1 -: 2];
              idx_q   <= idx_q + IDX_W'(1);
            end
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q   <= PREAMBLE;
            shreg_q   <= payload_q;
            a_q       <= PREAMBLE_SYM;
            a_valid_q <= 1'b1;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_milley_sequence_transmitter.sv
// Scoreboard bench for milley_sequence_transmitter: expected symbols are queued
// when a transmission is started and popped as the DUT hands symbols over.
module tb_milley_sequence_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       start1;
  logic       ready;
  logic [7:0] data_in;
  logic [3:0] repeat_count;

  logic [1:0] a0, a1;
  logic       v0, v1, b0, b1, d0, d1;

  always #5 clk = ~clk;

  milley_sequence_transmitter #(.SYMBOLS(4), .GAP_CYCLES(2), .PREAMBLE_SYM(2'b11)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .repeat_count(repeat_count), .ready(ready),
    .a(a0), .a_valid(v0), .busy(b0), .done(d0)
  );

  milley_sequence_transmitter #(.SYMBOLS(4), .GAP_CYCLES(0), .PREAMBLE_SYM(2'b11)) dut_nogap (
    .clk(clk), .reset(reset), .start(start1), .data_in(data_in),
    .repeat_count(repeat_count), .ready(ready),
    .a(a1), .a_valid(v1), .busy(b1), .done(d1)
  );

  typedef struct packed {
    logic       v;
    logic [1:0] a;
    logic       b;
    logic       d;
    logic       r;
  } ent_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] exp_q[$];
  ent_t       trace[$];

  logic [1:0] acc_q[$];
  int         runs_q[$];
  int         gaps_q[$];
  int         n_valid, n_done, done_idx, bad_idle_a, hold_viol;

  localparam logic [7:0] PAYLOAD = 8'b10_01_11_00;

  task automatic push_frames(input logic [7:0] d, input int frames);
    logic [7:0] dv;
    dv = d;
    for (int f = 0; f < frames; f++) begin
      exp_q.push_back(2'b11);
      for (int i = 0; i < 4; i++) exp_q.push_back(dv[7-2*i -: 2]);
    end
  endtask

  task automatic start_tx(input bit sel);
    @(posedge clk);
    #1;
    if (sel) start1 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic record(input int cycles, input bit sel);
    ent_t e;
    trace.delete();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (sel) e = '{v: v1, a: a1, b: b1, d: d1, r: ready};
      else     e = '{v: v0, a: a0, b: b0, d: d0, r: ready};
      trace.push_back(e);
    end
  endtask

  // Reduce a recorded trace to accepted symbols, run lengths and hazards.
  task automatic analyze();
    int cur, idle;
    bit seen;
    acc_q.delete(); runs_q.delete(); gaps_q.delete();
    n_valid = 0; n_done = 0; done_idx = -1; bad_idle_a = 0; hold_viol = 0;
    cur = 0; idle = 0; seen = 1'b0;
    for (int i = 0; i < trace.size(); i++) begin
      if (trace[i].v) begin
        n_valid++;
        if (cur == 0 && seen) gaps_q.push_back(idle);
        cur++;
        if (trace[i].r) acc_q.push_back(trace[i].a);
        else if (i + 1 < trace.size() &&
                 (!trace[i+1].v || trace[i+1].a != trace[i].a)) hold_viol++;
      end else begin
        if (cur > 0) begin runs_q.push_back(cur); seen = 1'b1; idle = 0; end
        cur = 0;
        idle++;
        if (trace[i].a != 2'b00) bad_idle_a++;
      end
      if (trace[i].d) begin
        n_done++;
        if (done_idx < 0) done_idx = i;
      end
    end
    if (cur > 0) runs_q.push_back(cur);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; start1 = 1'b0; ready = 1'b1;
    data_in = PAYLOAD; repeat_count = 4'd0;
    #2;
    n_checks++;
    if ({a0, v0, b0, d0} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 00000", {a0, v0, b0, d0});
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({a1, v1, b1, d1} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs_nogap: got %b want 00000", {a1, v1, b1, d1});
    end
  endtask

  task automatic test_basic();
    // Release reset and raise start together: the very next edge must take it.
    @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b1;
    push_frames(PAYLOAD, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    record(8, 1'b0);
    analyze();
    n_checks++;
    if (acc_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL basic_count: got %0d want %0d", acc_q.size(), exp_q.size());
    end
    while (acc_q.size() > 0 && exp_q.size() > 0) begin
      logic [1:0] got, want;
      got = acc_q.pop_front(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL basic_sym: got %b want %b", got, want); end
    end
    exp_q.delete();
    n_checks++;
    if (trace[0].v !== 1'b1 || trace[0].a !== 2'b11) begin
      n_fail++; $display("FAIL basic_first_cycle: got v=%b a=%b want v=1 a=11", trace[0].v, trace[0].a);
    end
    n_checks++;
    if (runs_q.size() != 1 || runs_q[0] != 5) begin
      n_fail++; $display("FAIL basic_valid_run: got %0d runs, n_valid=%0d want one run of 5", runs_q.size(), n_valid);
    end
    n_checks++;
    if (n_done != 1 || done_idx != 5) begin
      n_fail++; $display("FAIL basic_done: got count=%0d idx=%0d want 1 at 5", n_done, done_idx);
    end
    n_checks++;
    if (trace[5].b !== 1'b0 || trace[4].b !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy: got busy4=%b busy5=%b want 1 0", trace[4].b, trace[5].b);
    end
  endtask

  task automatic test_repeat();
    repeat_count = 4'd1;
    push_frames(PAYLOAD, 2);
    start_tx(1'b0);
    record(16, 1'b0);
    analyze();
    while (acc_q.size() > 0 && exp_q.size() > 0) begin
      logic [1:0] got, want;
      got = acc_q.pop_front(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL repeat_sym: got %b want %b", got, want); end
    end
    n_checks++;
    if (acc_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL repeat_count: leftover got %0d want %0d", acc_q.size(), exp_q.size());
    end
    exp_q.delete();
    n_checks++;
    if (runs_q.size() != 2 || gaps_q.size() != 1 || runs_q[0] != 5 || runs_q[1] != 5 || gaps_q[0] != 2) begin
      n_fail++; $display("FAIL repeat_shape: got runs=%0d gaps=%0d valid=%0d want 5,gap 2,5", runs_q.size(), gaps_q.size(), n_valid);
    end
    n_checks++;
    if (bad_idle_a != 0 || trace[5].b !== 1'b1 || trace[6].b !== 1'b1) begin
      n_fail++; $display("FAIL repeat_gap_outputs: got bad_a=%0d busy=%b%b want 0 11", bad_idle_a, trace[5].b, trace[6].b);
    end
    n_checks++;
    if (n_done != 1 || done_idx != 12) begin
      n_fail++; $display("FAIL repeat_done: got count=%0d idx=%0d want 1 at 12", n_done, done_idx);
    end
    repeat_count = 4'd0;
  endtask

  task automatic test_stall();
    push_frames(PAYLOAD, 1);
    start_tx(1'b0);
    fork
      record(12, 1'b0);
      begin
        @(posedge clk);
        #1 ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready = 1'b1;
      end
    join
    analyze();
    while (acc_q.size() > 0 && exp_q.size() > 0) begin
      logic [1:0] got, want;
      got = acc_q.pop_front(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL stall_sym: got %b want %b", got, want); end
    end
    n_checks++;
    if (acc_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL stall_count: leftover got %0d want %0d", acc_q.size(), exp_q.size());
    end
    exp_q.delete();
    n_checks++;
    if (hold_viol != 0 || trace[3].v !== 1'b1 || trace[3].a !== 2'b10 || trace[4].a !== 2'b10) begin
      n_fail++; $display("FAIL stall_hold: got viol=%0d a3=%b a4=%b want 0 10 10", hold_viol, trace[3].a, trace[4].a);
    end
    n_checks++;
    if (trace[5].a !== 2'b01 || n_valid != 8) begin
      n_fail++; $display("FAIL stall_resume: got a5=%b valid=%0d want 01 8", trace[5].a, n_valid);
    end
    n_checks++;
    if (n_done != 1 || done_idx != 8) begin
      n_fail++; $display("FAIL stall_done: got count=%0d idx=%0d want 1 at 8", n_done, done_idx);
    end
  endtask

  task automatic test_ignore();
    push_frames(PAYLOAD, 1);
    start_tx(1'b0);
    fork
      record(12, 1'b0);
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        data_in = 8'hFF; repeat_count = 4'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    analyze();
    while (acc_q.size() > 0 && exp_q.size() > 0) begin
      logic [1:0] got, want;
      got = acc_q.pop_front(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL ignore_sym: got %b want %b", got, want); end
    end
    n_checks++;
    if (acc_q.size() != 0 || exp_q.size() != 0 || n_valid != 5) begin
      n_fail++; $display("FAIL ignore_count: got valid=%0d leftover=%0d/%0d want 5 0/0", n_valid, acc_q.size(), exp_q.size());
    end
    exp_q.delete();
    n_checks++;
    if (n_done != 1 || runs_q.size() != 1) begin
      n_fail++; $display("FAIL ignore_frames: got done=%0d runs=%0d want 1 1", n_done, runs_q.size());
    end
    data_in = PAYLOAD; repeat_count = 4'd0;
  endtask

  task automatic test_reset_mid();
    int dn;
    start_tx(1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    n_checks++;
    if (a0 !== 2'b01 || v0 !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: got a=%b v=%b want 01 1", a0, v0);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({a0, v0, b0, d0} !== 5'b0) begin
      n_fail++; $display("FAIL midreset_async: got %b want 00000", {a0, v0, b0, d0});
    end
    dn = 0;
    repeat (3) begin @(negedge clk); if (d0) dn++; end
    @(posedge clk);
    #1 reset = 1'b1;
    record(4, 1'b0);
    analyze();
    n_checks++;
    if (dn != 0 || n_done != 0 || n_valid != 0 || trace[3].b !== 1'b0) begin
      n_fail++; $display("FAIL midreset_idle: got done=%0d/%0d valid=%0d want 0 0 0", dn, n_done, n_valid);
    end
    push_frames(PAYLOAD, 1);
    start_tx(1'b0);
    record(8, 1'b0);
    analyze();
    while (acc_q.size() > 0 && exp_q.size() > 0) begin
      logic [1:0] got, want;
      got = acc_q.pop_front(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL midreset_sym: got %b want %b", got, want); end
    end
    n_checks++;
    if (acc_q.size() != 0 || exp_q.size() != 0 || n_done != 1) begin
      n_fail++; $display("FAIL midreset_restart: got leftover=%0d/%0d done=%0d want 0/0 1", acc_q.size(), exp_q.size(), n_done);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    repeat_count = 4'd2;
    push_frames(PAYLOAD, 3);
    start_tx(1'b1);
    record(18, 1'b1);
    analyze();
    while (acc_q.size() > 0 && exp_q.size() > 0) begin
      logic [1:0] got, want;
      got = acc_q.pop_front(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL b2b_sym: got %b want %b", got, want); end
    end
    n_checks++;
    if (acc_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: leftover got %0d want %0d", acc_q.size(), exp_q.size());
    end
    exp_q.delete();
    n_checks++;
    if (runs_q.size() != 1 || runs_q[0] != 15) begin
      n_fail++; $display("FAIL b2b_run: got runs=%0d valid=%0d want one run of 15", runs_q.size(), n_valid);
    end
    n_checks++;
    if (n_done != 1 || done_idx != 15) begin
      n_fail++; $display("FAIL b2b_done: got count=%0d idx=%0d want 1 at 15", n_done, done_idx);
    end
    repeat_count = 4'd0;
  endtask

  task automatic test_max_repeat();
    repeat_count = 4'd15;
    push_frames(PAYLOAD, 16);
    start_tx(1'b0);
    record(114, 1'b0);
    analyze();
    n_checks++;
    if (acc_q.size() != 80) begin
      n_fail++; $display("FAIL maxrep_count: got %0d want 80", acc_q.size());
    end
    while (acc_q.size() > 0 && exp_q.size() > 0) begin
      logic [1:0] got, want;
      got = acc_q.pop_front(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL maxrep_sym: got %b want %b", got, want); end
    end
    exp_q.delete();
    n_checks++;
    if (runs_q.size() != 16 || gaps_q.size() != 15) begin
      n_fail++; $display("FAIL maxrep_frames: got runs=%0d gaps=%0d want 16 15", runs_q.size(), gaps_q.size());
    end
    n_checks++;
    if (n_done != 1 || done_idx != 110) begin
      n_fail++; $display("FAIL maxrep_done: got count=%0d idx=%0d want 1 at 110", n_done, done_idx);
    end
    repeat_count = 4'd0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_stall();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_max_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
